// File: rtl/rr_onehot_arbiter_if.sv
// rtl/rr_onehot_arbiter_if.sv - request/grant bundle for rr_onehot_arbiter (lock signal present only with ARB_LOCK_EN)
interface rr_onehot_arbiter_if #(
  parameter int N_REQ = 8,
  parameter int CNT_W = 16
);
  logic [N_REQ-1:0] req;
  logic             gnt_ready;
`ifdef ARB_LOCK_EN
  logic             lock;
`endif
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic [CNT_W-1:0] gnt_cnt;

`ifdef ARB_LOCK_EN
  // Arbiter side: consumes requests and handshake, drives the grant.
  modport master (
    input  req, gnt_ready, lock,
    output gnt, gnt_valid, gnt_cnt
  );

  // Requester/consumer side.
  modport slave (
    output req, gnt_ready, lock,
    input  gnt, gnt_valid, gnt_cnt
  );
`else
  // Arbiter side: consumes requests and handshake, drives the grant.
  modport master (
    input  req, gnt_ready,
    output gnt, gnt_valid, gnt_cnt
  );

  // Requester/consumer side.
  modport slave (
    output req, gnt_ready,
    input  gnt, gnt_valid, gnt_cnt
  );
`endif
endinterface

// File: rtl/rr_onehot_arbiter.sv
// rtl/rr_onehot_arbiter.sv - registered 8-way round-robin one-hot arbiter; optional winner lock via ARB_LOCK_EN
module rr_onehot_arbiter #(
  parameter int N_REQ = 8,   // must stay 8: the downstream 8-to-3 encoder and 3-bit pointer assume it
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_onehot_arbiter_if.master bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       win_q, win_d;       // binary index of the grant currently held
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       pick_idle;          // {found, index} scanning from the current pointer
  logic [3:0]       pick_hs;            // {found, index} scanning from the post-handshake pointer
  logic [2:0]       next_ptr;
  logic             relock;

  // First set request bit at or above p, wrapping mod 8; the returned MSB flags whether any bit was set.
  function automatic logic [3:0] rr_pick(input logic [N_REQ-1:0] r, input logic [2:0] p);
    logic       found;
    logic [2:0] idx;
    logic [2:0] k;
    found = 1'b0;
    idx   = p;
    for (int i = 0; i < N_REQ; i++) begin
      k = p + 3'(i);
      if (!found && r[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [2:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Lock re-grants the holder only while it is still requesting; otherwise fall back to round-robin.
  always_comb begin
`ifdef ARB_LOCK_EN
    relock = bus.lock && bus.req[win_q];
`else
    relock = 1'b0;
`endif
  end

  // Next-state: arbitration in IDLE, hold or handshake-and-rearbitrate in GRANT.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    cnt_d       = cnt_q;
    next_ptr    = win_q + 3'd1;
    pick_idle   = rr_pick(bus.req, ptr_q);
    pick_hs     = rr_pick(bus.req, next_ptr);

    case (state_q)
      ST_IDLE: begin
        if (pick_idle[3]) begin
          win_d       = pick_idle[2:0];
          gnt_d       = onehot(pick_idle[2:0]);
          gnt_valid_d = 1'b1;
          state_d     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (bus.gnt_ready) begin
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (!relock) begin
            ptr_d = next_ptr;
            if (pick_hs[3]) begin
              win_d = pick_hs[2:0];
              gnt_d = onehot(pick_hs[2:0]);
            end else begin
              gnt_d       = '0;
              gnt_valid_d = 1'b0;
              state_d     = ST_IDLE;
            end
          end
        end
      end
      default: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any pending grant without counting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 3'd0;
      win_q       <= 3'd0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_cnt   = cnt_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb/tb_rr_onehot_arbiter.sv - directed-vector bench for rr_onehot_arbiter (lock scenario when ARB_LOCK_EN is defined)
module tb_rr_onehot_arbiter;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  rr_onehot_arbiter_if #(.N_REQ(8), .CNT_W(16)) bus ();

  rr_onehot_arbiter #(.N_REQ(8), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req       = 8'h00;
    bus.gnt_ready = 1'b0;
`ifdef ARB_LOCK_EN
    bus.lock      = 1'b0;
`endif
    #3;
    n_vec++;
    if ({bus.gnt, bus.gnt_valid, bus.gnt_cnt} !== {8'h00, 1'b0, 16'd0}) begin
      n_err++;
      $display("FAIL reset: gnt=%h valid=%b cnt=%0d, want gnt=00 valid=0 cnt=0",
               bus.gnt, bus.gnt_valid, bus.gnt_cnt);
    end
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if ({bus.gnt, bus.gnt_valid, bus.gnt_cnt} !== {8'h00, 1'b0, 16'd0}) begin
        n_err++;
        $display("FAIL idle[%0d]: gnt=%h valid=%b cnt=%0d, want gnt=00 valid=0 cnt=0",
                 i, bus.gnt, bus.gnt_valid, bus.gnt_cnt);
      end
    end
  endtask

  // req=FF with ready held: 01,02,...,80,01 then accept the last one (cnt 9).
  task automatic test_rotation();
    logic [7:0] exp_gnt;
    bus.req       = 8'hFF;
    bus.gnt_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_gnt = 8'h01 << ((k - 1) % 8);
      n_vec++;
      if ({bus.gnt, bus.gnt_valid, bus.gnt_cnt} !== {exp_gnt, 1'b1, 16'(k - 1)}) begin
        n_err++;
        $display("FAIL rotation[%0d]: gnt=%h valid=%b cnt=%0d, want gnt=%h valid=1 cnt=%0d",
                 k, bus.gnt, bus.gnt_valid, bus.gnt_cnt, exp_gnt, k - 1);
      end
    end
    bus.req = 8'h00;
    step();
    n_vec++;
    if ({bus.gnt, bus.gnt_valid, bus.gnt_cnt} !== {8'h00, 1'b0, 16'd9}) begin
      n_err++;
      $display("FAIL rotation_end: gnt=%h valid=%b cnt=%0d, want gnt=00 valid=0 cnt=9",
               bus.gnt, bus.gnt_valid, bus.gnt_cnt);
    end
  endtask

  // ptr=1: req=24 wins bit2, held 4 cycles, then bit5 after handshake.
  task automatic test_hold();
    bus.req       = 8'h24;
    bus.gnt_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_vec++;
      if ({bus.gnt, bus.gnt_valid, bus.gnt_cnt} !== {8'h04, 1'b1, 16'd9}) begin
        n_err++;
        $display("FAIL hold[%0d]: gnt=%h valid=%b cnt=%0d, want gnt=04 valid=1 cnt=9",
                 k, bus.gnt, bus.gnt_valid, bus.gnt_cnt);
      end
    end
    bus.gnt_ready = 1'b1;
    step();
    n_vec++;
    if ({bus.gnt, bus.gnt_valid, bus.gnt_cnt} !== {8'h20, 1'b1, 16'd10}) begin
      n_err++;
      $display("FAIL hold_next: gnt=%h valid=%b cnt=%0d, want gnt=20 valid=1 cnt=10",
               bus.gnt, bus.gnt_valid, bus.gnt_cnt);
    end
    bus.req = 8'h00;
    step();
    n_vec++;
    if ({bus.gnt, bus.gnt_valid, bus.gnt_cnt} !== {8'h00, 1'b0, 16'd11}) begin
      n_err++;
      $display("FAIL hold_end: gnt=%h valid=%b cnt=%0d, want gnt=00 valid=0 cnt=11",
               bus.gnt, bus.gnt_valid, bus.gnt_cnt);
    end
  endtask

  // ptr=6: grant 10 held after req drops, cleared on accept; ready ignored while idle.
  task automatic test_req_drop();
    bus.req       = 8'h10;
    bus.gnt_ready = 1'b0;
    step();
    bus.req = 8'h00;
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++;
      if ({bus.gnt, bus.gnt_valid, bus.gnt_cnt} !== {8'h10, 1'b1, 16'd11}) begin
        n_err++;
        $display("FAIL drop_hold[%0d]: gnt=%h valid=%b cnt=%0d, want gnt=10 valid=1 cnt=11",
                 k, bus.gnt, bus.gnt_valid, bus.gnt_cnt);
      end
    end
    bus.gnt_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++;
      if ({bus.gnt, bus.gnt_valid, bus.gnt_cnt} !== {8'h00, 1'b0, 16'd12}) begin
        n_err++;
        $display("FAIL drop_accept[%0d]: gnt=%h valid=%b cnt=%0d, want gnt=00 valid=0 cnt=12",
                 k, bus.gnt, bus.gnt_valid, bus.gnt_cnt);
      end
    end
  endtask

  // ptr=5: grant 08, async reset mid-grant, then req=88 must pick bit3 (ptr back at 0).
  task automatic test_reset_mid_grant();
    bus.req       = 8'h08;
    bus.gnt_ready = 1'b0;
    step();
    n_vec++;
    if ({bus.gnt, bus.gnt_valid} !== {8'h08, 1'b1}) begin
      n_err++;
      $display("FAIL pre_reset: gnt=%h valid=%b, want gnt=08 valid=1", bus.gnt, bus.gnt_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.gnt, bus.gnt_valid, bus.gnt_cnt} !== {8'h00, 1'b0, 16'd0}) begin
      n_err++;
      $display("FAIL async_reset: gnt=%h valid=%b cnt=%0d, want gnt=00 valid=0 cnt=0",
               bus.gnt, bus.gnt_valid, bus.gnt_cnt);
    end
    step();
    rst_n   = 1'b1;
    bus.req = 8'h88;
    step();
    n_vec++;
    if ({bus.gnt, bus.gnt_valid, bus.gnt_cnt} !== {8'h08, 1'b1, 16'd0}) begin
      n_err++;
      $display("FAIL post_reset: gnt=%h valid=%b cnt=%0d, want gnt=08 valid=1 cnt=0",
               bus.gnt, bus.gnt_valid, bus.gnt_cnt);
    end
    bus.req       = 8'h00;
    bus.gnt_ready = 1'b1;
    step();
    n_vec++;
    if ({bus.gnt, bus.gnt_valid, bus.gnt_cnt} !== {8'h00, 1'b0, 16'd1}) begin
      n_err++;
      $display("FAIL post_reset_accept: gnt=%h valid=%b cnt=%0d, want gnt=00 valid=0 cnt=1",
               bus.gnt, bus.gnt_valid, bus.gnt_cnt);
    end
  endtask

`ifdef ARB_LOCK_EN
  // ptr=4: req=03 locked re-grants 01 and counts each accept; unlock moves on to 02.
  task automatic test_lock();
    bus.req       = 8'h03;
    bus.lock      = 1'b1;
    bus.gnt_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_vec++;
      if ({bus.gnt, bus.gnt_valid, bus.gnt_cnt} !== {8'h01, 1'b1, 16'(k)}) begin
        n_err++;
        $display("FAIL lock[%0d]: gnt=%h valid=%b cnt=%0d, want gnt=01 valid=1 cnt=%0d",
                 k, bus.gnt, bus.gnt_valid, bus.gnt_cnt, k);
      end
    end
    bus.lock = 1'b0;
    step();
    n_vec++;
    if ({bus.gnt, bus.gnt_valid, bus.gnt_cnt} !== {8'h02, 1'b1, 16'd4}) begin
      n_err++;
      $display("FAIL unlock: gnt=%h valid=%b cnt=%0d, want gnt=02 valid=1 cnt=4",
               bus.gnt, bus.gnt_valid, bus.gnt_cnt);
    end
    bus.req = 8'h00;
    step();
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_idle();
    test_rotation();
    test_hold();
    test_req_drop();
    test_reset_mid_grant();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
